// File: rtl/glitch_cmd_sender_pkg.sv
// Command vocabulary shared by the glitcher command sender and the receive-side decoder.
// Holds the opcode enumeration, ASCII command bytes, payload lengths and sender FSM states.
package glitch_cmd_sender_pkg;

   typedef enum logic [2:0] {
      OpDelay     = 3'd0,
      OpWidth     = 3'd1,
      OpNumPulses = 3'd2,
      OpSpacing   = 3'd3,
      OpRstLen    = 3'd4,
      OpPulseGo   = 3'd5,
      OpRstGo     = 3'd6,
      OpArm       = 3'd7
   } glitch_op_e;

   localparam logic [7:0] AsciiDelay     = 8'h64;  // 'd'
   localparam logic [7:0] AsciiWidth     = 8'h77;  // 'w'
   localparam logic [7:0] AsciiNumPulses = 8'h6E;  // 'n'
   localparam logic [7:0] AsciiSpacing   = 8'h73;  // 's'
   localparam logic [7:0] AsciiRstLen    = 8'h6C;  // 'l'
   localparam logic [7:0] AsciiPulseGo   = 8'h67;  // 'g'
   localparam logic [7:0] AsciiRstGo     = 8'h72;  // 'r'
   localparam logic [7:0] AsciiArm       = 8'h61;  // 'a'

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StSend,
      StDone
   } send_state_e;

   function automatic logic [7:0] op_ascii(glitch_op_e op);
      logic [7:0] b;
      unique case (op)
         OpDelay:     b = AsciiDelay;
         OpWidth:     b = AsciiWidth;
         OpNumPulses: b = AsciiNumPulses;
         OpSpacing:   b = AsciiSpacing;
         OpRstLen:    b = AsciiRstLen;
         OpPulseGo:   b = AsciiPulseGo;
         OpRstGo:     b = AsciiRstGo;
         OpArm:       b = AsciiArm;
         default:     b = AsciiArm;
      endcase
      return b;
   endfunction

   function automatic logic [1:0] op_payload_len(glitch_op_e op);
      logic [1:0] n;
      unique case (op)
         OpDelay, OpSpacing, OpRstLen: n = 2'd2;
         OpWidth, OpNumPulses:         n = 2'd1;
         default:                      n = 2'd0;
      endcase
      return n;
   endfunction

   // Receive-side lookup: maps a command byte back to its opcode, flagging unknown bytes.
   function automatic logic ascii_to_op(input logic [7:0] b, output glitch_op_e op);
      logic known;
      known = 1'b1;
      unique case (b)
         AsciiDelay:     op = OpDelay;
         AsciiWidth:     op = OpWidth;
         AsciiNumPulses: op = OpNumPulses;
         AsciiSpacing:   op = OpSpacing;
         AsciiRstLen:    op = OpRstLen;
         AsciiPulseGo:   op = OpPulseGo;
         AsciiRstGo:     op = OpRstGo;
         AsciiArm:       op = OpArm;
         default: begin
            op    = OpArm;
            known = 1'b0;
         end
      endcase
      return known;
   endfunction

endpackage

// File: rtl/glitch_cmd_sender_if.sv
// Command request channel into the glitcher command sender.
interface glitch_cmd_sender_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic [15:0] cmd_data;

   modport master (
      output cmd_valid,
      output cmd_op,
      output cmd_data,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_op,
      input  cmd_data,
      output cmd_ready
   );
endinterface

// File: rtl/glitch_cmd_sender_uart_tx.sv
// Single-byte 8N1 serializer with a registered line output.
// A new start may be taken in the last stop-bit cycle so consecutive bytes abut.
module uart_tx #(
   parameter int unsigned ClksPerBit = 10  // must be >= 2
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       start_i,
   input  logic [7:0] byte_in_i,
   output logic       busy_o,
   output logic       done_o,
   output logic       tx_o
);

   localparam int unsigned CntW = (ClksPerBit > 2) ? $clog2(ClksPerBit) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(ClksPerBit - 1);
   localparam logic [CntW-1:0] CntDone = CntW'(ClksPerBit - 2);

   logic            active_q, active_d;
   logic            line_q, line_d;
   logic [8:0]      shift_q, shift_d;
   logic [3:0]      bit_q, bit_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            bit_end, frame_end, take;

   always_comb begin
      active_d  = active_q;
      line_d    = line_q;
      shift_d   = shift_q;
      bit_d     = bit_q;
      cnt_d     = cnt_q;
      bit_end   = (cnt_q == CntLast);
      frame_end = active_q && bit_end && (bit_q == 4'd9);
      take      = start_i && (!active_q || frame_end);

      if (take) begin
         active_d = 1'b1;
         line_d   = 1'b0;
         shift_d  = {1'b1, byte_in_i};
         bit_d    = 4'd0;
         cnt_d    = '0;
      end else if (active_q) begin
         if (bit_end) begin
            cnt_d = '0;
            if (bit_q == 4'd9) begin
               active_d = 1'b0;
               line_d   = 1'b1;
            end else begin
               // Bit index 1..8 carry data LSB first; index 9 is the stop bit shifted in.
               line_d  = shift_q[0];
               shift_d = {1'b1, shift_q[8:1]};
               bit_d   = bit_q + 4'd1;
            end
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      // done fires one cycle early so the next byte can be handed over in the final stop cycle.
      done_o = active_q && (bit_q == 4'd9) && (cnt_q == CntDone);
      busy_o = active_q && !frame_end;
      tx_o   = line_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         active_q <= 1'b0;
         line_q   <= 1'b1;
         shift_q  <= '1;
         bit_q    <= 4'd0;
         cnt_q    <= '0;
      end else begin
         active_q <= active_d;
         line_q   <= line_d;
         shift_q  <= shift_d;
         bit_q    <= bit_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/glitch_cmd_sender.sv
// Turns one accepted command into an opcode byte plus 0-2 payload bytes on the glitcher UART.
// Bytes of a command go out back-to-back; the line is idle again before cmd_ready returns.
module glitch_cmd_sender
   import glitch_cmd_sender_pkg::*;
#(
   parameter int unsigned CLK_FREQ  = 50_000_000,
   parameter int unsigned BAUD_RATE = 115200
) (
   input  logic                clk,
   input  logic                rst,
   glitch_cmd_sender_if.slave  cmd,
   output logic                uart_tx_o,
   output logic                busy_o
);

   localparam int unsigned ClksPerBit = CLK_FREQ / BAUD_RATE;

   send_state_e state_q, state_d;
   glitch_op_e  op_q, op_d;
   logic [15:0] data_q, data_d;
   logic [1:0]  rem_q, rem_d;
   logic        op_sent_q, op_sent_d;

   logic        accept;
   logic        tx_start;
   logic [7:0]  tx_byte;
   logic        tx_busy;
   logic        tx_done;

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      data_d    = data_q;
      rem_d     = rem_q;
      op_sent_d = op_sent_q;
      tx_start  = 1'b0;
      tx_byte   = 8'h00;
      accept    = cmd.cmd_valid && (state_q == StIdle) && !rst;

      cmd.cmd_ready = (state_q == StIdle) && !rst;
      busy_o        = (state_q != StIdle) && !rst;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               op_d      = glitch_op_e'(cmd.cmd_op);
               data_d    = cmd.cmd_data;
               rem_d     = op_payload_len(glitch_op_e'(cmd.cmd_op));
               op_sent_d = 1'b0;
               state_d   = StLoad;
            end
         end
         StLoad: begin
            tx_start = 1'b1;
            if (!op_sent_q) begin
               tx_byte = op_ascii(op_q);
            end else begin
               tx_byte = (rem_q == 2'd2) ? data_q[15:8] : data_q[7:0];
               rem_d   = rem_q - 2'd1;
            end
            op_sent_d = 1'b1;
            state_d   = StSend;
         end
         StSend: begin
            // The last byte is held until its stop bit is on the line so cmd_ready
            // never returns while the frame is still in flight.
            if (rem_q != 2'd0) begin
               if (tx_done) begin
                  state_d = StLoad;
               end
            end else if (!tx_busy) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         op_q      <= OpDelay;
         data_q    <= 16'h0000;
         rem_q     <= 2'd0;
         op_sent_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         data_q    <= data_d;
         rem_q     <= rem_d;
         op_sent_q <= op_sent_d;
      end
   end

   uart_tx #(
      .ClksPerBit(ClksPerBit)
   ) u_uart_tx (
      .clk_i    (clk),
      .rst_i    (rst),
      .start_i  (tx_start),
      .byte_in_i(tx_byte),
      .busy_o   (tx_busy),
      .done_o   (tx_done),
      .tx_o     (uart_tx_o)
   );

endmodule

// File: tb/tb_glitch_cmd_sender.sv
// Self-checking bench: random and directed commands, a UART line receiver and a byte-level model.
module tb_glitch_cmd_sender;

   localparam int unsigned BitClks  = 10;
   localparam int unsigned ByteClks = 10 * BitClks;

   logic clk = 1'b0;
   logic rst;
   logic uart_tx;
   logic busy;

   glitch_cmd_sender_if cmd_if ();

   glitch_cmd_sender #(
      .CLK_FREQ (1_000_000),
      .BAUD_RATE(100_000)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cmd      (cmd_if),
      .uart_tx_o(uart_tx),
      .busy_o   (busy)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Command table: ASCII letter per opcode and number of payload bytes.
   function automatic logic [7:0] exp_ascii(input logic [2:0] op);
      string letters;
      letters = "dwnslgra";
      return letters[int'(op)];
   endfunction

   function automatic int exp_len(input logic [2:0] op);
      case (op)
         3'd0, 3'd3, 3'd4: return 2;
         3'd1, 3'd2:       return 1;
         default:          return 0;
      endcase
   endfunction

   // Line receiver: samples each 8N1 bit at its centre.
   logic [7:0]  rx_byte_q[$];
   int unsigned rx_start_q[$];
   bit          rx_ok_q[$];
   logic [7:0]  rx_log_q[$];

   always begin : line_mon
      logic [7:0]  b;
      int unsigned s;
      bit          ok;
      @(negedge clk);
      if (uart_tx === 1'b0) begin
         s  = cyc;
         ok = 1'b1;
         repeat (BitClks / 2) @(negedge clk);
         if (uart_tx !== 1'b0) ok = 1'b0;
         for (int i = 0; i < 8; i++) begin
            repeat (BitClks) @(negedge clk);
            b[i] = uart_tx;
         end
         repeat (BitClks) @(negedge clk);
         if (uart_tx !== 1'b1) ok = 1'b0;
         rx_byte_q.push_back(b);
         rx_start_q.push_back(s);
         rx_ok_q.push_back(ok);
         rx_log_q.push_back(b);
         repeat (BitClks / 2 - 1) @(negedge clk);
      end
   end

   int unsigned prev_last_start = 0;
   bit          have_prev = 1'b0;

   // Issues one command and checks bytes, timing, busy length and that busy-time offers are ignored.
   task automatic run_cmd(input logic [2:0] op, input logic [15:0] data, input bit chained);
      int unsigned acc, busy_n, n, guard, last;
      bit          ready_seen;
      logic [7:0]  exp_b[$];
      logic [7:0]  b;
      int unsigned s;
      bit          ok;
      if (!chained) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         guard = 0;
         while (cmd_if.cmd_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
         end
      end
      check_eq("ready_in_idle", cmd_if.cmd_ready, 1);
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_op    = op;
      cmd_if.cmd_data  = data;
      acc              = cyc;
      @(negedge clk);
      busy_n     = 0;
      ready_seen = 1'b0;
      guard      = 0;
      while (busy === 1'b1 && guard < 2000) begin
         busy_n++;
         if (cmd_if.cmd_ready !== 1'b0) ready_seen = 1'b1;
         cmd_if.cmd_valid = 1'($urandom);
         cmd_if.cmd_op    = 3'($urandom);
         cmd_if.cmd_data  = 16'($urandom);
         @(negedge clk);
         guard++;
      end
      cmd_if.cmd_valid = 1'b0;

      n = 1 + exp_len(op);
      exp_b.push_back(exp_ascii(op));
      if (exp_len(op) == 2) exp_b.push_back(data[15:8]);
      if (exp_len(op) >= 1) exp_b.push_back(data[7:0]);

      check_eq("busy_cycles", busy_n, 2 + ByteClks * n);
      check_eq("ready_low_while_busy", ready_seen, 0);
      check_eq("byte_count", rx_byte_q.size(), n);
      last = 0;
      if (rx_byte_q.size() >= n) begin
         for (int i = 0; i < n; i++) begin
            b  = rx_byte_q.pop_front();
            s  = rx_start_q.pop_front();
            ok = rx_ok_q.pop_front();
            check_eq("byte_value", b, exp_b[i]);
            check_eq("framing", ok, 1);
            if (i == 0) begin
               check_eq("start_latency", s - acc, 2);
               if (chained && have_prev) check_eq("inter_cmd_gap", s - prev_last_start - ByteClks, 3);
            end else begin
               check_eq("back_to_back", s - last, ByteClks);
            end
            last = s;
         end
      end
      rx_byte_q.delete();
      rx_start_q.delete();
      rx_ok_q.delete();
      prev_last_start = last;
      have_prev       = 1'b1;
   endtask

   initial begin : watchdog
      #900_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int unsigned acc;
      int unsigned delay_reg, width_reg, go_cnt, idx;
      logic [7:0]  c;

      rst              = 1'b1;
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_op    = 3'd0;
      cmd_if.cmd_data  = 16'h0000;
      repeat (3) @(negedge clk);
      check_eq("rst_tx_high", uart_tx, 1);
      check_eq("rst_busy_low", busy, 0);
      check_eq("rst_ready_low", cmd_if.cmd_ready, 0);
      rst = 1'b0;
      @(negedge clk);
      check_eq("ready_after_rst", cmd_if.cmd_ready, 1);

      // Directed: two-byte payload, one-byte payload with ignored MSB, chained zero-payload pair.
      run_cmd(3'd0, 16'h1234, 1'b0);
      run_cmd(3'd1, 16'hAB05, 1'b0);
      run_cmd(3'd5, 16'h0000, 1'b0);
      run_cmd(3'd7, 16'h0000, 1'b1);

      // Reset in the middle of the second byte of a spacing command.
      while (cmd_if.cmd_ready !== 1'b1) @(negedge clk);
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_op    = 3'd3;
      cmd_if.cmd_data  = 16'hBEEF;
      acc              = cyc;
      @(negedge clk);
      cmd_if.cmd_valid = 1'b0;
      repeat (149) @(negedge clk);
      check_eq("midframe_busy", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      check_eq("midrst_tx_high", uart_tx, 1);
      check_eq("midrst_busy_low", busy, 0);
      check_eq("midrst_ready_low", cmd_if.cmd_ready, 0);
      rst = 1'b0;
      @(negedge clk);
      check_eq("midrst_ready_after", cmd_if.cmd_ready, 1);
      repeat (120) @(negedge clk);
      rx_byte_q.delete();
      rx_start_q.delete();
      rx_ok_q.delete();
      have_prev = 1'b0;
      run_cmd(3'd6, 16'($urandom), 1'b0);

      // Receiver-side view: decode the byte stream into glitcher settings.
      rx_log_q.delete();
      run_cmd(3'd0, 16'h0010, 1'b0);
      run_cmd(3'd1, 16'h0004, 1'b0);
      run_cmd(3'd5, 16'h0000, 1'b0);
      delay_reg = 0;
      width_reg = 0;
      go_cnt    = 0;
      idx       = 0;
      while (idx < rx_log_q.size()) begin
         c = rx_log_q[idx];
         idx++;
         if (c == "d" && idx + 1 < rx_log_q.size() + 1) begin
            delay_reg = {16'h0, rx_log_q[idx], rx_log_q[idx+1]};
            idx += 2;
         end else if (c == "w") begin
            width_reg = {24'h0, rx_log_q[idx]};
            idx += 1;
         end else if (c == "g") begin
            go_cnt++;
         end
      end
      check_eq("loop_delay", delay_reg, 16);
      check_eq("loop_width", width_reg, 4);
      check_eq("loop_go_strobes", go_cnt, 1);

      // Random commands, some offered on the first idle cycle after the previous one.
      for (int k = 0; k < 14; k++) begin
         run_cmd(3'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
      end

      repeat (20) @(negedge clk);
      check_eq("final_line_idle", uart_tx, 1);
      check_eq("final_not_busy", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
